dispmem_write_sched: RTL and testbench
======================================

# dispmem_write_sched

Write-port scheduler for the display memory. It shares the single display-memory write port between two requesters:
- the host write stream (valid/ready);
- a built-in fill engine that writes a constant word over an address range, e.g. screen clear or row blanking.

It sits between the host/control logic and the `display_wr_en_i/addr_i/data_i` inputs of `video_main`. A fill can be deferred until the next end-of-frame strobe, and arbitration guarantees the host at least every other write slot during a fill.

## Interface
Parameters:
- `ADDR_W`, default `v::DISPADDR_W`: display memory address width.
- `DATA_W`, default `v::DISPDATA_W`: display memory data width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_ni`  in  1  reset, synchronous, active-low.
- `end_of_frame_i`  in  1  one-cycle end-of-frame strobe from video timing.
- `host_valid_i`  in  1  host write request.
- `host_ready_o`  out  1  host write slot available; a transfer occurs when `host_valid_i & host_ready_o`.
- `host_addr_i`  in  ADDR_W  host write address.
- `host_data_i`  in  DATA_W  host write data.
- `fill_start_i`  in  1  fill start pulse; sampled only in IDLE.
- `fill_vsync_i`  in  1  qualifier for `fill_start_i`; 1 = defer fill to next `end_of_frame_i`.
- `fill_addr_i`  in  ADDR_W  fill base address; latched at start.
- `fill_count_i`  in  ADDR_W  number of words to fill; latched at start.
- `fill_data_i`  in  DATA_W  fill word; latched at start.
- `fill_abort_i`  in  1  cancel a pending or running fill.
- `fill_busy_o`  out  1  high in WAIT_VS or RUN.
- `fill_done_o`  out  1  one-cycle strobe on completion.
- `wr_en_o`  out  1  display memory write enable (registered).
- `wr_addr_o`  out  ADDR_W  display memory write address (registered).
- `wr_data_o`  out  DATA_W  display memory write data (registered).

## Operation
States: IDLE, WAIT_VS, RUN.

IDLE:
- `host_ready_o`=1; every host transfer is written.
- `fill_start_i`=1 latches addr/count/data.
- If count==0: no writes; `fill_done_o` pulses next cycle; stay IDLE.
- Else if `fill_vsync_i`=1: go to WAIT_VS.
- Else: go to RUN.

WAIT_VS:
- `host_ready_o`=1.
- On `end_of_frame_i`, go to RUN next cycle.
- An `end_of_frame_i` in the same cycle as `fill_start_i` (while in IDLE) does not count; the fill waits for the following strobe.

RUN:
- One write slot per cycle. `last_grant` flag is set to HOST on RUN entry, so the first RUN slot goes to the fill.
- `host_ready_o` = (`last_grant`==FILL), registered-state-derived and independent of `host_valid_i`.
- If `host_valid_i` and `host_ready_o`: host wins; `last_grant` becomes HOST.
- Otherwise: fill wins; `last_grant` becomes FILL.
- Each fill grant writes at the current address, then increments the address modulo 2^ADDR_W (wrap from all-ones to 0) and decrements remaining.
- The grant that takes remaining from 1 to 0 returns to IDLE.

Abort and restart:
- `fill_abort_i` in WAIT_VS or RUN returns to IDLE next cycle. No `fill_done_o` pulse. The grant in the abort cycle still completes. Abort in IDLE is ignored.
- `fill_start_i` outside IDLE is ignored; latched parameters do not change.
- Abort and start in the same cycle: abort wins, start is dropped.

## Timing
- Reset (`reset_ni`=0 at a clock edge):
  - state=IDLE, `last_grant`=HOST.
  - `wr_en_o`, `wr_addr_o`, `wr_data_o`, `fill_busy_o`, `fill_done_o` all 0.
  - `host_ready_o` forced 0 while `reset_ni` is low.
  - Reset mid-fill discards the fill; no done pulse and no further writes.
- Write latency: a grant (host or fill) in cycle N gives `wr_en_o`=1 with its addr/data in N+1. `wr_en_o` is 0 in cycles with no grant.
- `fill_done_o` pulses in the same cycle as `wr_en_o` for the last fill word. For count==0, it pulses the cycle after start.
- `fill_busy_o` is registered: high from the cycle after accepted start until the cycle after the last grant or abort.
- Throughput:
  - With both requesters continuously pending, grants strictly alternate FILL, HOST, FILL, …
  - A host-idle fill of C words takes C consecutive cycles.
  - Maximum host stall is 1 cycle.
- `fill_count_i` is unsigned; the maximum fill is 2^ADDR_W−1 words.

## Test plan
- Reset, then host writes addr 0x010/0x011 data 0xA5A5/0x5A5A back-to-back -> `host_ready_o`=1; `wr_en_o` in the following two cycles with matching addr/data; `fill_busy_o`=0.
- Fill base 0x100, count 4, data 0x0020, `fill_vsync_i`=0, host idle -> writes to 0x100..0x103 on 4 consecutive cycles; `fill_done_o` pulses with the 0x103 write.
- Fill count 6 with host streaming valid writes -> `wr_en_o` every cycle, alternating fill/host starting with fill at 0x100; all 6 fill and 6 host words written; host never stalls more than 1 cycle.
- `fill_vsync_i`=1 with start coincident with an `end_of_frame_i` -> no fill write until after the next `end_of_frame_i`; first fill write two cycles after that strobe.
- Fill base all-ones−1, count 3 -> writes to all-ones−1, all-ones, then 0.
- Abort after 2 fill writes of count 10; separately, drive `reset_ni`=0 mid-fill; and start with count 0 -> abort/reset: no done, writes stop, `fill_busy_o` falls; count 0: `fill_done_o` the next cycle with zero writes.

Source files
------------

// File: rtl/dispmem_write_sched.sv
// Display-memory write-port scheduler: shares one registered write port between the
// host stream and a constant-word fill engine that can defer to end-of-frame.
package v;
  localparam int DISPADDR_W = 12;
  localparam int DISPDATA_W = 16;
endpackage

module dispmem_write_sched #(
  parameter int ADDR_W = v::DISPADDR_W,
  parameter int DATA_W = v::DISPDATA_W
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              end_of_frame_i,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic              fill_start_i,
  input  logic              fill_vsync_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [ADDR_W-1:0] fill_count_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              fill_abort_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, RUN} state_t;

  state_t            state, state_nx;
  logic              last_fill;  // previous RUN slot went to the fill engine
  logic [ADDR_W-1:0] fill_ptr, fill_left;
  logic [DATA_W-1:0] fill_word;
  logic              start_ok, host_grant, fill_grant, fill_last;

  always_ff @(posedge clk) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok && fill_count_i != '0) state_nx = fill_vsync_i ? WAIT_VS : RUN;
      WAIT_VS: if (fill_abort_i) state_nx = IDLE;
               else if (end_of_frame_i) state_nx = RUN;
      RUN:     if (fill_abort_i || fill_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Host readiness depends only on registered state so it never combinationally loops on valid.
  always_comb begin
    host_ready_o = reset_ni && (state != RUN || last_fill);
    host_grant   = host_valid_i && host_ready_o;
    fill_grant   = (state == RUN) && !host_grant;
    fill_last    = fill_grant && (fill_left == ADDR_W'(1));
    start_ok     = (state == IDLE) && fill_start_i && !fill_abort_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      fill_busy_o <= 1'b0;
      fill_done_o <= 1'b0;
      last_fill   <= 1'b0;
      fill_ptr    <= '0;
      fill_left   <= '0;
      fill_word   <= '0;
    end else begin
      wr_en_o     <= host_grant || fill_grant;
      fill_busy_o <= (state_nx != IDLE);
      fill_done_o <= (start_ok && fill_count_i == '0) || (fill_last && !fill_abort_i);
      last_fill   <= fill_grant;
      if (host_grant) begin
        wr_addr_o <= host_addr_i;
        wr_data_o <= host_data_i;
      end else if (fill_grant) begin
        wr_addr_o <= fill_ptr;
        wr_data_o <= fill_word;
      end
      if (start_ok) begin
        fill_ptr  <= fill_addr_i;
        fill_left <= fill_count_i;
        fill_word <= fill_data_i;
      end else if (fill_grant) begin
        fill_ptr  <= fill_ptr + ADDR_W'(1);
        fill_left <= fill_left - ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dispmem_write_sched.sv
// Scoreboard bench: a slot-level reference model predicts every write-port event,
// and an independent monitor pops and compares whenever the port shows activity.
module tb_dispmem_write_sched;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_ni, end_of_frame_i, host_valid_i, host_ready_o;
  logic [AW-1:0] host_addr_i, fill_addr_i, fill_count_i, wr_addr_o;
  logic [DW-1:0] host_data_i, fill_data_i, wr_data_o;
  logic          fill_start_i, fill_vsync_i, fill_abort_i;
  logic          fill_busy_o, fill_done_o, wr_en_o;

  dispmem_write_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_ni(reset_ni), .end_of_frame_i(end_of_frame_i),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
    .host_addr_i(host_addr_i), .host_data_i(host_data_i),
    .fill_start_i(fill_start_i), .fill_vsync_i(fill_vsync_i),
    .fill_addr_i(fill_addr_i), .fill_count_i(fill_count_i),
    .fill_data_i(fill_data_i), .fill_abort_i(fill_abort_i),
    .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o));

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 = no fill, 1 = waiting for frame end, 2 = filling
  int            m_mode = 0;
  bit            m_host_had_slot = 1'b1;
  logic [AW-1:0] m_ptr = '0;
  logic [DW-1:0] m_word = '0;
  int            m_left = 0;
  bit            last_hg = 1'b0;
  int            stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Evaluate the current cycle's inputs against the model, then advance one clock.
  task automatic tick();
    exp_t e;
    bit   hg, rdy;
    int   old;
    #1;
    last_hg = 1'b0;
    if (!reset_ni) begin
      chk("ready_in_reset", host_ready_o, 0);
      m_mode = 0;
      m_host_had_slot = 1'b1;
      stall = 0;
    end else begin
      rdy = (m_mode != 2) || !m_host_had_slot;
      chk("host_ready", host_ready_o, rdy);
      chk("fill_busy", fill_busy_o, m_mode != 0);
      if (host_valid_i && !host_ready_o) stall++;
      else if (host_valid_i) begin
        if (stall > 0) chk("host_stall_le1", stall <= 1, 1);
        stall = 0;
      end
      hg = host_valid_i && rdy;
      e.wr = 1'b0; e.addr = '0; e.data = '0; e.done = 1'b0; e.cyc = cyc + 1;
      if (hg) begin e.wr = 1'b1; e.addr = host_addr_i; e.data = host_data_i; end
      old = m_mode;
      if (old == 2) begin
        if (!hg) begin
          e.wr = 1'b1; e.addr = m_ptr; e.data = m_word;
          e.done = (m_left == 1) && !fill_abort_i;
          m_ptr = m_ptr + 1'b1;
          m_left--;
          m_host_had_slot = 1'b0;
          if (m_left == 0) m_mode = 0;
        end else m_host_had_slot = 1'b1;
        if (fill_abort_i) m_mode = 0;
      end else if (old == 1) begin
        if (fill_abort_i) m_mode = 0;
        else if (end_of_frame_i) begin m_mode = 2; m_host_had_slot = 1'b1; end
      end else if (fill_start_i && !fill_abort_i) begin
        m_ptr = fill_addr_i; m_word = fill_data_i; m_left = int'(fill_count_i);
        if (m_left == 0) e.done = 1'b1;
        else begin m_mode = fill_vsync_i ? 1 : 2; m_host_had_slot = 1'b1; end
      end
      if (e.wr || e.done) q.push_back(e);
      last_hg = hg;
    end
    @(posedge clk);
    #1;
  endtask

  // One cycle; a host stream that just transferred offers a fresh word.
  task automatic step();
    tick();
    if (last_hg) begin
      host_addr_i = AW'($urandom);
      host_data_i = DW'($urandom);
    end
  endtask

  task automatic start_fill(input logic [AW-1:0] a, input logic [AW-1:0] c,
                            input logic [DW-1:0] d, input logic vs);
    fill_addr_i = a; fill_count_i = c; fill_data_i = d; fill_vsync_i = vs;
    fill_start_i = 1'b1;
    step();
    fill_start_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    tick();
    tick();
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    chk("rst_busy", fill_busy_o, 0);
    chk("rst_done", fill_done_o, 0);
    reset_ni = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (wr_en_o || fill_done_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: wr_en=%0b addr=%0h data=%0h done=%0b (cycle %0d)",
                 wr_en_o, wr_addr_o, wr_data_o, fill_done_o, cyc);
      end else begin
        e = q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("wr_en", wr_en_o, e.wr);
        if (e.wr) begin
          chk("wr_addr", wr_addr_o, e.addr);
          chk("wr_data", wr_data_o, e.data);
        end
        chk("fill_done", fill_done_o, e.done);
      end
    end
  end

  initial begin
    reset_ni = 1'b0; end_of_frame_i = 1'b0; host_valid_i = 1'b0;
    host_addr_i = '0; host_data_i = '0; fill_start_i = 1'b0; fill_vsync_i = 1'b0;
    fill_addr_i = '0; fill_count_i = '0; fill_data_i = '0; fill_abort_i = 1'b0;
    #1;
    do_reset();

    // Back-to-back host writes
    host_valid_i = 1'b1; host_addr_i = 12'h010; host_data_i = 16'hA5A5; tick();
    host_addr_i = 12'h011; host_data_i = 16'h5A5A; tick();
    host_valid_i = 1'b0; tick(); tick();

    // Plain fill, host idle
    start_fill(12'h100, 12'd4, 16'h0020, 1'b0);
    repeat (6) step();

    // Fill against a continuous host stream
    host_valid_i = 1'b1; host_addr_i = 12'h040; host_data_i = 16'h1234;
    start_fill(12'h100, 12'd6, 16'h00C3, 1'b0);
    repeat (14) step();
    host_valid_i = 1'b0;
    repeat (2) step();

    // Deferred fill; the coincident frame strobe must not count
    end_of_frame_i = 1'b1;
    start_fill(12'h200, 12'd3, 16'h3333, 1'b1);
    end_of_frame_i = 1'b0;
    repeat (5) step();
    end_of_frame_i = 1'b1; step(); end_of_frame_i = 1'b0;
    repeat (6) step();

    // Address wrap
    start_fill(12'hFFE, 12'd3, 16'h7777, 1'b0);
    repeat (5) step();

    // Abort after two fill writes
    start_fill(12'h300, 12'd10, 16'h0A0A, 1'b0);
    step(); step();
    fill_abort_i = 1'b1; step(); fill_abort_i = 1'b0;
    repeat (4) step();

    // Reset in the middle of a fill
    start_fill(12'h400, 12'd10, 16'h0B0B, 1'b0);
    repeat (3) step();
    do_reset();
    repeat (3) step();

    // Zero-length fill
    start_fill(12'h500, 12'd0, 16'h0C0C, 1'b0);
    repeat (3) step();

    // Randomized traffic
    repeat (3000) begin
      reset_ni       = ($urandom % 400) != 0;
      host_valid_i   = 1'($urandom);
      host_addr_i    = AW'($urandom);
      host_data_i    = DW'($urandom);
      fill_start_i   = ($urandom % 12) == 0;
      fill_vsync_i   = 1'($urandom);
      fill_addr_i    = ($urandom % 4 == 0) ? AW'(12'hFF8 + 12'($urandom % 8)) : AW'($urandom);
      fill_count_i   = AW'($urandom % 14);
      fill_data_i    = DW'($urandom);
      end_of_frame_i = ($urandom % 20) == 0;
      fill_abort_i   = ($urandom % 40) == 0;
      tick();
    end

    reset_ni = 1'b1; host_valid_i = 1'b0; fill_start_i = 1'b0;
    end_of_frame_i = 1'b0; fill_abort_i = 1'b1;
    step();
    fill_abort_i = 1'b0;
    repeat (4) step();
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
